// File: rtl/pdm_clk_gen_prog_if.sv
// Control/status bundle for pdm_clk_gen_prog. m_clk_falling exists only when
// PDM_CLK_FALLING_EN is defined.
interface pdm_clk_gen_prog_if #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned DEC_W = 8
);
  logic             en;
  logic [DIV_W-1:0] half_period_i;
  logic [DEC_W-1:0] dec_ratio_i;
  logic             cfg_load;
  logic             cfg_pending;
  logic             MIC_CLK;
  logic             m_clk_rising;
  logic             pcm_strobe;
  logic             running;
`ifdef PDM_CLK_FALLING_EN
  logic             m_clk_falling;

  modport master (
    output en, half_period_i, dec_ratio_i, cfg_load,
    input  cfg_pending, MIC_CLK, m_clk_rising, pcm_strobe, running, m_clk_falling
  );
  modport slave (
    input  en, half_period_i, dec_ratio_i, cfg_load,
    output cfg_pending, MIC_CLK, m_clk_rising, pcm_strobe, running, m_clk_falling
  );
`else
  modport master (
    output en, half_period_i, dec_ratio_i, cfg_load,
    input  cfg_pending, MIC_CLK, m_clk_rising, pcm_strobe, running
  );
  modport slave (
    input  en, half_period_i, dec_ratio_i, cfg_load,
    output cfg_pending, MIC_CLK, m_clk_rising, pcm_strobe, running
  );
`endif
endinterface

// File: rtl/pdm_clk_gen_prog.sv
// Runtime-programmable PDM mic clock generator with edge and PCM-rate strobes.
// Define PDM_CLK_FALLING_EN to add the m_clk_falling strobe.
module pdm_clk_gen_prog #(
  parameter int unsigned DIV_W        = 8,
  parameter int unsigned DEC_W        = 8,
  parameter int unsigned DEFAULT_HALF = 16,
  parameter int unsigned DEFAULT_DEC  = 64
) (
  input logic               clk,
  input logic               rst,
  pdm_clk_gen_prog_if.slave bus
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRun      = 2'd1;
  localparam logic [1:0] StStopping = 2'd2;

  localparam logic [DIV_W-1:0] HalfRst = DIV_W'(DEFAULT_HALF);
  localparam logic [DEC_W-1:0] DecRst  = DEC_W'(DEFAULT_DEC);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             mic_q, mic_d;
  logic             rise_q, rise_d;
  logic             pcm_q, pcm_d;
  logic [DIV_W-1:0] half_act_q, half_sh_q;
  logic [DEC_W-1:0] dec_act_q, dec_sh_q;
  logic             pend_q;
`ifdef PDM_CLK_FALLING_EN
  logic             fall_q;
`endif
  logic             fall_d;

  logic             at_end, dec_wrap, fall_tog, apply;
  logic [DIV_W-1:0] half_clamp;
  logic [DEC_W-1:0] dec_clamp;

  assign at_end     = (div_cnt_q == half_act_q - DIV_W'(1));
  assign dec_wrap   = (dec_cnt_q == dec_act_q - DEC_W'(1));
  // Any non-idle state with MIC_CLK high is counting toward the falling toggle.
  assign fall_tog   = (state_q != StIdle) && mic_q && at_end;
  assign apply      = pend_q && ((state_q == StIdle) || fall_tog);
  assign half_clamp = (bus.half_period_i == '0) ? DIV_W'(1) : bus.half_period_i;
  assign dec_clamp  = (bus.dec_ratio_i == '0) ? DEC_W'(1) : bus.dec_ratio_i;

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    dec_cnt_d = dec_cnt_q;
    mic_d     = mic_q;
    rise_d    = 1'b0;
    pcm_d     = 1'b0;
    fall_d    = 1'b0;
    case (state_q)
      StIdle: begin
        mic_d     = 1'b0;
        div_cnt_d = '0;
        dec_cnt_d = '0;
        if (bus.en) state_d = StRun;
      end
      StRun, StStopping: begin
        if (state_q == StStopping && !bus.en && !mic_q) begin
          // Low phase may be cut short when stopping.
          state_d   = StIdle;
          div_cnt_d = '0;
          dec_cnt_d = '0;
        end else begin
          state_d = bus.en ? StRun : StStopping;
          if (at_end) begin
            div_cnt_d = '0;
            mic_d     = ~mic_q;
            if (!mic_q) begin
              rise_d = 1'b1;
              if (dec_wrap) begin
                dec_cnt_d = '0;
                pcm_d     = 1'b1;
              end else begin
                dec_cnt_d = dec_cnt_q + DEC_W'(1);
              end
            end else begin
              fall_d = 1'b1;
              if (state_q == StStopping && !bus.en) begin
                state_d   = StIdle;
                dec_cnt_d = '0;
              end
            end
          end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
          end
        end
      end
      default: begin
        state_d   = StIdle;
        mic_d     = 1'b0;
        div_cnt_d = '0;
        dec_cnt_d = '0;
      end
    endcase
    if (apply) begin
      div_cnt_d = '0;
      dec_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_cnt_q <= '0;
      dec_cnt_q <= '0;
      mic_q     <= 1'b0;
      rise_q    <= 1'b0;
      pcm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      mic_q     <= mic_d;
      rise_q    <= rise_d;
      pcm_q     <= pcm_d;
    end
  end

  // Shadow overwrite and apply are independent: a load on the apply cycle keeps
  // pending set while the previous shadow goes live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_act_q <= HalfRst;
      dec_act_q  <= DecRst;
      half_sh_q  <= HalfRst;
      dec_sh_q   <= DecRst;
      pend_q     <= 1'b0;
    end else begin
      if (apply) begin
        half_act_q <= half_sh_q;
        dec_act_q  <= dec_sh_q;
      end
      if (bus.cfg_load) begin
        half_sh_q <= half_clamp;
        dec_sh_q  <= dec_clamp;
      end
      pend_q <= bus.cfg_load || (pend_q && !apply);
    end
  end

`ifdef PDM_CLK_FALLING_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) fall_q <= 1'b0;
    else     fall_q <= fall_d;
  end
  assign bus.m_clk_falling = fall_q;
`else
  logic unused_fall;
  assign unused_fall = fall_d;
`endif

  assign bus.MIC_CLK      = mic_q;
  assign bus.m_clk_rising = rise_q;
  assign bus.pcm_strobe   = pcm_q;
  assign bus.cfg_pending  = pend_q;
  assign bus.running      = (state_q != StIdle);

endmodule

// File: tb/tb_pdm_clk_gen_prog.sv
// Self-checking bench for pdm_clk_gen_prog: vector table, hand sequences for
// reset/period corners, and randomized lockstep against a behavioural model.
module tb_pdm_clk_gen_prog;

  logic clk;
  logic rst;

  pdm_clk_gen_prog_if #(.DIV_W(8), .DEC_W(8)) bus ();

  pdm_clk_gen_prog #(
    .DIV_W(8), .DEC_W(8), .DEFAULT_HALF(16), .DEFAULT_DEC(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.MIC_CLK, bus.m_clk_rising, bus.pcm_strobe, bus.cfg_pending, bus.running};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Behavioural model: elapsed cycles in the current phase, rising edges counted
  // since the last decimation restart, pcm when that count is a multiple of dec.
  bit m_run, m_drain, m_mic, m_rise, m_pcm, m_pend;
`ifdef PDM_CLK_FALLING_EN
  bit m_fall;
`endif
  int m_elapsed, m_rises, m_half, m_dec, m_sh_half, m_sh_dec;

  task automatic model_reset();
    m_run = 0; m_drain = 0; m_mic = 0; m_rise = 0; m_pcm = 0; m_pend = 0;
`ifdef PDM_CLK_FALLING_EN
    m_fall = 0;
`endif
    m_elapsed = 0; m_rises = 0;
    m_half = 16; m_dec = 64; m_sh_half = 16; m_sh_dec = 64;
  endtask

  task automatic model_step(input bit en, input bit load, input int h, input int d);
    bit apply;
    apply = 0; m_rise = 0; m_pcm = 0;
`ifdef PDM_CLK_FALLING_EN
    m_fall = 0;
`endif
    if (!m_run) begin
      apply = m_pend; m_mic = 0; m_elapsed = 0; m_rises = 0;
      if (en) begin m_run = 1; m_drain = 0; end
    end else if (m_drain && !en && !m_mic) begin
      m_run = 0; m_elapsed = 0; m_rises = 0;
    end else begin
      if (m_elapsed + 1 >= m_half) begin
        m_elapsed = 0;
        if (!m_mic) begin
          m_mic = 1; m_rise = 1; m_rises++;
          m_pcm = (m_rises % m_dec) == 0;
        end else begin
          m_mic = 0; apply = m_pend;
`ifdef PDM_CLK_FALLING_EN
          m_fall = 1;
`endif
          if (m_drain && !en) begin m_run = 0; m_rises = 0; end
        end
      end else begin
        m_elapsed++;
      end
      if (m_run) m_drain = !en;
    end
    if (apply) begin
      m_half = m_sh_half; m_dec = m_sh_dec; m_rises = 0; m_elapsed = 0; m_pend = 0;
    end
    if (load) begin
      m_sh_half = (h == 0) ? 1 : h;
      m_sh_dec  = (d == 0) ? 1 : d;
      m_pend    = 1;
    end
  endtask

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] half;
    logic [7:0] dec;
    int         cycles;
    logic [4:0] exp;  // {MIC_CLK, m_clk_rising, pcm_strobe, cfg_pending, running}
  } vec_t;

  localparam int NV = 22;
  vec_t tbl[NV];

  initial begin
    int n;
    tbl[0]  = '{1'b0, 1'b0, 8'd0, 8'd0,  2, 5'b00000};
    tbl[1]  = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b00001};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 8'd0, 15, 5'b00001};
    tbl[3]  = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b11001};
    tbl[4]  = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b10001};
    tbl[5]  = '{1'b1, 1'b0, 8'd0, 8'd0, 15, 5'b00001};
    tbl[6]  = '{1'b1, 1'b1, 8'd4, 8'd2,  1, 5'b00011};
    tbl[7]  = '{1'b1, 1'b0, 8'd0, 8'd0, 15, 5'b11011};
    tbl[8]  = '{1'b1, 1'b0, 8'd0, 8'd0, 16, 5'b00001};
    tbl[9]  = '{1'b1, 1'b0, 8'd0, 8'd0,  4, 5'b11001};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 8'd0,  4, 5'b00001};
    tbl[11] = '{1'b1, 1'b0, 8'd0, 8'd0,  4, 5'b11101};
    tbl[12] = '{1'b0, 1'b0, 8'd0, 8'd0,  1, 5'b10001};
    tbl[13] = '{1'b0, 1'b0, 8'd0, 8'd0,  2, 5'b10001};
    tbl[14] = '{1'b0, 1'b0, 8'd0, 8'd0,  1, 5'b00000};
    tbl[15] = '{1'b0, 1'b0, 8'd0, 8'd0,  3, 5'b00000};
    tbl[16] = '{1'b0, 1'b1, 8'd0, 8'd0,  1, 5'b00010};
    tbl[17] = '{1'b0, 1'b0, 8'd0, 8'd0,  1, 5'b00000};
    tbl[18] = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b00001};
    tbl[19] = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b11101};
    tbl[20] = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b00001};
    tbl[21] = '{1'b1, 1'b0, 8'd0, 8'd0,  1, 5'b11101};

    rst = 1'b1;
    bus.en = 1'b0; bus.cfg_load = 1'b0; bus.half_period_i = '0; bus.dec_ratio_i = '0;
    repeat (3) @(negedge clk);
    check("reset_state", outs(), 5'b00000);
`ifdef PDM_CLK_FALLING_EN
    check("reset_falling", bus.m_clk_falling, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.en = tbl[i].en; bus.cfg_load = tbl[i].load;
      bus.half_period_i = tbl[i].half; bus.dec_ratio_i = tbl[i].dec;
      for (int c = 0; c < tbl[i].cycles; c++) begin
        step();
        bus.cfg_load = 1'b0;
      end
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Reset while running with a config pending; pending value must be dropped.
    bus.en = 1'b1; bus.half_period_i = 8'd5; bus.dec_ratio_i = 8'd3; bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
    step();
    check("pre_reset", outs(), 5'b11111);
    rst = 1'b1;
    #1;
    check("async_reset", outs(), 5'b00000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    n = 0;
    while (n < 100 && !bus.MIC_CLK) begin step(); n++; end
    check("first_rise_delay", n, 17);
    check("pending_discarded", bus.cfg_pending, 0);
    check("first_rise_strobe", bus.m_clk_rising, 1);
    n = 0;
    while (n < 100 && bus.MIC_CLK) begin step(); n++; end
    check("high_len", n, 16);
    n = 0;
    while (n < 100 && !bus.MIC_CLK) begin step(); n++; end
    check("low_len", n, 16);

    n = 0;
    while (n < 3000 && !bus.pcm_strobe) begin step(); n++; end
    check("pcm_found", bus.pcm_strobe, 1);
    check("pcm_with_rise", bus.m_clk_rising, 1);
    n = 0;
    do begin step(); n++; end while (n < 3000 && !bus.pcm_strobe);
    check("pcm_period", n, 2048);

    // Randomized lockstep against the model.
    rst = 1'b1;
    bus.en = 1'b0; bus.cfg_load = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 9) == 0) bus.en = ~bus.en;
      bus.cfg_load      = ($urandom_range(0, 15) == 0);
      bus.half_period_i = 8'($urandom_range(0, 6));
      bus.dec_ratio_i   = 8'($urandom_range(0, 4));
      @(posedge clk);
      model_step(bus.en, bus.cfg_load, int'(bus.half_period_i), int'(bus.dec_ratio_i));
      @(negedge clk);
      check($sformatf("rand%0d", k), outs(), {m_mic, m_rise, m_pcm, m_pend, m_run});
`ifdef PDM_CLK_FALLING_EN
      check($sformatf("rand_fall%0d", k), bus.m_clk_falling, m_fall);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
